// File: rtl/rrf_alloc_file.sv
// Rename register file with a circular tag allocator, two write-back ports and in-order commit.
// Define RRF_WB_BYPASS_EN to forward same-cycle write-back data to the read and commit ports.
module rrf_alloc_file #(
    parameter int unsigned RRF_NUM  = 64,
    parameter int unsigned RRF_SEL  = 6,
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                alloc_req_i,
    output logic                alloc_rdy_o,
    output logic [RRF_SEL-1:0]  alloc_tag_o,
    output logic [RRF_SEL:0]    free_cnt_o,
    input  logic                wb1_en_i,
    input  logic                wb2_en_i,
    input  logic [RRF_SEL-1:0]  wb1_tag_i,
    input  logic [RRF_SEL-1:0]  wb2_tag_i,
    input  logic [DATA_LEN-1:0] wb1_data_i,
    input  logic [DATA_LEN-1:0] wb2_data_i,
    input  logic [RRF_SEL-1:0]  rs1_tag_i,
    input  logic [RRF_SEL-1:0]  rs2_tag_i,
    output logic [DATA_LEN-1:0] rs1_data_o,
    output logic [DATA_LEN-1:0] rs2_data_o,
    output logic                rs1_valid_o,
    output logic                rs2_valid_o,
    input  logic                com_en_i,
    output logic [RRF_SEL-1:0]  com_tag_o,
    output logic [DATA_LEN-1:0] com_data_o,
    output logic                com_valid_o
);

    localparam logic [RRF_SEL:0] FULL = (RRF_SEL+1)'(RRF_NUM);

    logic [RRF_SEL-1:0]  head_q, head_d, tail_q, tail_d;
    logic [RRF_SEL:0]    used_q, used_d;
    logic [RRF_NUM-1:0]  valid_q, valid_d;
    logic [DATA_LEN-1:0] data_q [RRF_NUM];

    logic head_valid;
    logic alloc_fire;
    logic com_fire;

    assign alloc_rdy_o = (used_q != FULL);
    assign alloc_tag_o = tail_q;
    assign free_cnt_o  = FULL - used_q;
    assign com_tag_o   = head_q;
    assign com_valid_o = (used_q != '0) && head_valid;
    assign alloc_fire  = alloc_req_i && alloc_rdy_o;
    assign com_fire    = com_en_i && com_valid_o;

    always_comb begin
        rs1_valid_o = valid_q[rs1_tag_i];
        rs1_data_o  = data_q[rs1_tag_i];
        rs2_valid_o = valid_q[rs2_tag_i];
        rs2_data_o  = data_q[rs2_tag_i];
        head_valid  = valid_q[head_q];
        com_data_o  = data_q[head_q];
`ifdef RRF_WB_BYPASS_EN
        // wb2 is applied last so it overrides wb1 on a shared tag.
        if (wb1_en_i && (wb1_tag_i == rs1_tag_i)) begin
            rs1_valid_o = 1'b1;
            rs1_data_o  = wb1_data_i;
        end
        if (wb2_en_i && (wb2_tag_i == rs1_tag_i)) begin
            rs1_valid_o = 1'b1;
            rs1_data_o  = wb2_data_i;
        end
        if (wb1_en_i && (wb1_tag_i == rs2_tag_i)) begin
            rs2_valid_o = 1'b1;
            rs2_data_o  = wb1_data_i;
        end
        if (wb2_en_i && (wb2_tag_i == rs2_tag_i)) begin
            rs2_valid_o = 1'b1;
            rs2_data_o  = wb2_data_i;
        end
        if (wb1_en_i && (wb1_tag_i == head_q)) begin
            head_valid = 1'b1;
            com_data_o = wb1_data_i;
        end
        if (wb2_en_i && (wb2_tag_i == head_q)) begin
            head_valid = 1'b1;
            com_data_o = wb2_data_i;
        end
`endif
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        used_d  = used_q;
        valid_d = valid_q;
        if (flush_i) begin
            tail_d  = head_q;
            used_d  = '0;
            valid_d = '0;
        end else begin
            if (wb1_en_i) valid_d[wb1_tag_i] = 1'b1;
            if (wb2_en_i) valid_d[wb2_tag_i] = 1'b1;
            // Allocation clear is applied after write-back so it wins on a collision.
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            if (com_fire) head_d = head_q + 1'b1;
            case ({alloc_fire, com_fire})
                2'b10:   used_d = used_q + 1'b1;
                2'b01:   used_d = used_q - 1'b1;
                default: used_d = used_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            used_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            used_q  <= used_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            if (wb1_en_i) data_q[wb1_tag_i] <= wb1_data_i;
            if (wb2_en_i) data_q[wb2_tag_i] <= wb2_data_i;
        end
    end

endmodule

// File: tb/tb_rrf_alloc_file.sv
// Self-checking bench for rrf_alloc_file: allocation, wrap, write-back, commit, flush and async reset.
module tb_rrf_alloc_file;

    localparam int RRF_NUM  = 64;
    localparam int RRF_SEL  = 6;
    localparam int DATA_LEN = 32;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                flush_i;
    logic                alloc_req_i;
    logic                alloc_rdy_o;
    logic [RRF_SEL-1:0]  alloc_tag_o;
    logic [RRF_SEL:0]    free_cnt_o;
    logic                wb1_en_i, wb2_en_i;
    logic [RRF_SEL-1:0]  wb1_tag_i, wb2_tag_i;
    logic [DATA_LEN-1:0] wb1_data_i, wb2_data_i;
    logic [RRF_SEL-1:0]  rs1_tag_i, rs2_tag_i;
    logic [DATA_LEN-1:0] rs1_data_o, rs2_data_o;
    logic                rs1_valid_o, rs2_valid_o;
    logic                com_en_i;
    logic [RRF_SEL-1:0]  com_tag_o;
    logic [DATA_LEN-1:0] com_data_o;
    logic                com_valid_o;

    int checks = 0;
    int errors = 0;

    logic [RRF_SEL-1:0]  grant_q [$];
    logic [DATA_LEN-1:0] com_q [$];
    logic [RRF_SEL-1:0]  exp_tag;
    logic [DATA_LEN-1:0] exp_data;

    rrf_alloc_file #(.RRF_NUM(RRF_NUM), .RRF_SEL(RRF_SEL), .DATA_LEN(DATA_LEN)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .alloc_req_i(alloc_req_i), .alloc_rdy_o(alloc_rdy_o),
        .alloc_tag_o(alloc_tag_o), .free_cnt_o(free_cnt_o),
        .wb1_en_i(wb1_en_i), .wb2_en_i(wb2_en_i),
        .wb1_tag_i(wb1_tag_i), .wb2_tag_i(wb2_tag_i),
        .wb1_data_i(wb1_data_i), .wb2_data_i(wb2_data_i),
        .rs1_tag_i(rs1_tag_i), .rs2_tag_i(rs2_tag_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .rs1_valid_o(rs1_valid_o), .rs2_valid_o(rs2_valid_o),
        .com_en_i(com_en_i), .com_tag_o(com_tag_o),
        .com_data_o(com_data_o), .com_valid_o(com_valid_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_i = 1'b0; flush_i = 1'b0; alloc_req_i = 1'b0; com_en_i = 1'b0;
        wb1_en_i = 1'b0; wb2_en_i = 1'b0; wb1_tag_i = '0; wb2_tag_i = '0;
        wb1_data_i = '0; wb2_data_i = '0; rs1_tag_i = '0; rs2_tag_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (alloc_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b want 1", alloc_rdy_o); end
        checks++; if (alloc_tag_o !== 6'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", alloc_tag_o); end
        checks++; if (free_cnt_o !== 7'd64) begin errors++; $display("FAIL reset_free got %0d want 64", free_cnt_o); end
        checks++; if (com_valid_o !== 1'b0) begin errors++; $display("FAIL reset_com_valid got %0b want 0", com_valid_o); end
        checks++; if (com_tag_o !== 6'd0) begin errors++; $display("FAIL reset_com_tag got %0d want 0", com_tag_o); end
        checks++; if (rs1_valid_o !== 1'b0 || rs2_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_rs_valid got %0b/%0b want 0/0", rs1_valid_o, rs2_valid_o);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < RRF_NUM; i++) begin
            @(negedge clk_i);
            alloc_req_i = 1'b1;
            grant_q.push_back(RRF_SEL'(i));
            #1;
            exp_tag = grant_q.pop_front();
            checks++; if (alloc_tag_o !== exp_tag || alloc_rdy_o !== 1'b1) begin
                errors++; $display("FAIL fill_grant got %0d rdy %0b want %0d rdy 1", alloc_tag_o, alloc_rdy_o, exp_tag);
            end
        end
        @(negedge clk_i);
        #1;
        checks++; if (alloc_rdy_o !== 1'b0 || free_cnt_o !== 7'd0) begin
            errors++; $display("FAIL full_state got rdy %0b free %0d want rdy 0 free 0", alloc_rdy_o, free_cnt_o);
        end
        @(negedge clk_i);
        alloc_req_i = 1'b0;
        #1;
        checks++; if (alloc_tag_o !== 6'd0 || free_cnt_o !== 7'd0) begin
            errors++; $display("FAIL full_ignore got tag %0d free %0d want tag 0 free 0", alloc_tag_o, free_cnt_o);
        end
    endtask

    task automatic test_commit_wrap();
        @(negedge clk_i);
        wb1_en_i = 1'b1; wb1_tag_i = 6'd0; wb1_data_i = 32'hDEADBEEF;
        com_q.push_back(32'hDEADBEEF);
        @(negedge clk_i);
        wb1_en_i = 1'b0; com_en_i = 1'b1; alloc_req_i = 1'b1;
        #1;
        exp_data = (com_q.size() != 0) ? com_q.pop_front() : 32'h0;
        checks++; if (com_valid_o !== 1'b1 || com_data_o !== exp_data || com_tag_o !== 6'd0) begin
            errors++; $display("FAIL commit_full got v %0b data %h tag %0d want v 1 data %h tag 0",
                               com_valid_o, com_data_o, com_tag_o, exp_data);
        end
        checks++; if (alloc_rdy_o !== 1'b0) begin errors++; $display("FAIL commit_full_rdy got %0b want 0", alloc_rdy_o); end
        @(negedge clk_i);
        com_en_i = 1'b0;
        #1;
        checks++; if (free_cnt_o !== 7'd1 || alloc_tag_o !== 6'd0 || com_tag_o !== 6'd1) begin
            errors++; $display("FAIL wrap_pre got free %0d tag %0d head %0d want 1/0/1", free_cnt_o, alloc_tag_o, com_tag_o);
        end
        @(negedge clk_i);
        alloc_req_i = 1'b0;
        #1;
        checks++; if (free_cnt_o !== 7'd0 || alloc_tag_o !== 6'd1) begin
            errors++; $display("FAIL wrap_post got free %0d tag %0d want 0/1", free_cnt_o, alloc_tag_o);
        end
    endtask

    task automatic test_wb_same_tag();
        @(negedge clk_i);
        wb1_en_i = 1'b1; wb1_tag_i = 6'd5; wb1_data_i = 32'h1111;
        wb2_en_i = 1'b1; wb2_tag_i = 6'd5; wb2_data_i = 32'h2222;
        rs1_tag_i = 6'd5; rs2_tag_i = 6'd5;
        #1;
`ifdef RRF_WB_BYPASS_EN
        checks++; if (rs1_valid_o !== 1'b1 || rs1_data_o !== 32'h2222) begin
            errors++; $display("FAIL wb_bypass got v %0b data %h want v 1 data 2222", rs1_valid_o, rs1_data_o);
        end
`else
        checks++; if (rs1_valid_o !== 1'b0) begin
            errors++; $display("FAIL wb_no_bypass got v %0b want 0", rs1_valid_o);
        end
`endif
        @(negedge clk_i);
        wb1_en_i = 1'b0; wb2_en_i = 1'b0;
        #1;
        checks++; if (rs1_valid_o !== 1'b1 || rs1_data_o !== 32'h2222 || rs2_data_o !== 32'h2222) begin
            errors++; $display("FAIL wb_same_tag got v %0b data %h/%h want v 1 data 2222", rs1_valid_o, rs1_data_o, rs2_data_o);
        end
    endtask

    task automatic test_commit_ignored();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; com_en_i = 1'b1;
        #1;
        checks++; if (com_valid_o !== 1'b0 || free_cnt_o !== 7'd64) begin
            errors++; $display("FAIL empty_commit_pre got v %0b free %0d want 0/64", com_valid_o, free_cnt_o);
        end
        @(negedge clk_i);
        com_en_i = 1'b0;
        #1;
        checks++; if (com_tag_o !== 6'd1 || free_cnt_o !== 7'd64 || alloc_tag_o !== 6'd1) begin
            errors++; $display("FAIL empty_commit got head %0d free %0d tail %0d want 1/64/1", com_tag_o, free_cnt_o, alloc_tag_o);
        end
        for (int i = 0; i < 10; i++) begin
            alloc_req_i = 1'b1;
            grant_q.push_back(RRF_SEL'(i + 1));
            #1;
            exp_tag = grant_q.pop_front();
            checks++; if (alloc_tag_o !== exp_tag) begin
                errors++; $display("FAIL alloc10_grant got %0d want %0d", alloc_tag_o, exp_tag);
            end
            @(negedge clk_i);
        end
        alloc_req_i = 1'b0; com_en_i = 1'b1;
        #1;
        checks++; if (com_valid_o !== 1'b0) begin errors++; $display("FAIL unwritten_head got v %0b want 0", com_valid_o); end
        @(negedge clk_i);
        com_en_i = 1'b0;
        #1;
        checks++; if (com_tag_o !== 6'd1 || free_cnt_o !== 7'd54) begin
            errors++; $display("FAIL unwritten_commit got head %0d free %0d want 1/54", com_tag_o, free_cnt_o);
        end
    endtask

    task automatic test_flush();
        wb1_en_i = 1'b1; wb1_tag_i = 6'd3; wb1_data_i = 32'h3333;
        wb2_en_i = 1'b1; wb2_tag_i = 6'd5; wb2_data_i = 32'h5555;
        rs1_tag_i = 6'd3; rs2_tag_i = 6'd5;
        @(negedge clk_i);
        wb1_en_i = 1'b0; wb2_en_i = 1'b0;
        #1;
        checks++; if (rs1_valid_o !== 1'b1 || rs2_valid_o !== 1'b1 || rs1_data_o !== 32'h3333) begin
            errors++; $display("FAIL preflush got v %0b/%0b data %h want 1/1 3333", rs1_valid_o, rs2_valid_o, rs1_data_o);
        end
        flush_i = 1'b1; alloc_req_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; alloc_req_i = 1'b0;
        #1;
        checks++; if (free_cnt_o !== 7'd64 || alloc_tag_o !== com_tag_o || alloc_tag_o !== 6'd1) begin
            errors++; $display("FAIL flush_ptrs got free %0d tail %0d head %0d want 64/1/1", free_cnt_o, alloc_tag_o, com_tag_o);
        end
        checks++; if (rs1_valid_o !== 1'b0 || rs2_valid_o !== 1'b0 || com_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_valid got %0b/%0b/%0b want 0/0/0", rs1_valid_o, rs2_valid_o, com_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        alloc_req_i = 1'b1;
        @(negedge clk_i);
        wb1_en_i = 1'b1; wb1_tag_i = 6'd1; wb1_data_i = 32'hCAFE0001;
        com_q.push_back(32'hCAFE0001);
        @(negedge clk_i);
        wb1_en_i = 1'b0; com_en_i = 1'b1;
        #1;
        exp_data = (com_q.size() != 0) ? com_q.pop_front() : 32'h0;
        checks++; if (com_valid_o !== 1'b1 || com_data_o !== exp_data || free_cnt_o !== 7'd62) begin
            errors++; $display("FAIL b2b_commit got v %0b data %h free %0d want 1 %h 62", com_valid_o, com_data_o, free_cnt_o, exp_data);
        end
        @(negedge clk_i);
        com_en_i = 1'b0;
        wb1_en_i = 1'b1; wb1_tag_i = 6'd4; wb1_data_i = 32'h4444; rs1_tag_i = 6'd4;
        #1;
        checks++; if (free_cnt_o !== 7'd62 || com_tag_o !== 6'd2 || alloc_tag_o !== 6'd4) begin
            errors++; $display("FAIL b2b_ptrs got free %0d head %0d tail %0d want 62/2/4", free_cnt_o, com_tag_o, alloc_tag_o);
        end
        @(negedge clk_i);
        wb1_en_i = 1'b0; alloc_req_i = 1'b0;
        #1;
        checks++; if (rs1_valid_o !== 1'b0 || free_cnt_o !== 7'd61) begin
            errors++; $display("FAIL alloc_clear_wins got v %0b free %0d want 0/61", rs1_valid_o, free_cnt_o);
        end
    endtask

    task automatic test_async_reset();
        alloc_req_i = 1'b1;
        repeat (4) @(negedge clk_i);
        alloc_req_i = 1'b0;
        #1;
        checks++; if (free_cnt_o !== 7'd57) begin errors++; $display("FAIL pre_reset_free got %0d want 57", free_cnt_o); end
        #2;
        reset_i = 1'b0;
        #1;
        checks++; if (alloc_tag_o !== 6'd0 || free_cnt_o !== 7'd64 || alloc_rdy_o !== 1'b1 ||
                      com_valid_o !== 1'b0 || com_tag_o !== 6'd0) begin
            errors++; $display("FAIL async_reset got tag %0d free %0d rdy %0b cv %0b head %0d want 0/64/1/0/0",
                               alloc_tag_o, free_cnt_o, alloc_rdy_o, com_valid_o, com_tag_o);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        alloc_req_i = 1'b1;
        grant_q.push_back(6'd0);
        #1;
        exp_tag = grant_q.pop_front();
        checks++; if (alloc_tag_o !== exp_tag) begin errors++; $display("FAIL post_reset_grant got %0d want %0d", alloc_tag_o, exp_tag); end
        @(negedge clk_i);
        alloc_req_i = 1'b0;
        #1;
        checks++; if (alloc_tag_o !== 6'd1 || free_cnt_o !== 7'd63) begin
            errors++; $display("FAIL post_reset_alloc got tag %0d free %0d want 1/63", alloc_tag_o, free_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_commit_wrap();
        test_wb_same_tag();
        test_commit_ignored();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
